rv_decode: RTL and testbench

Combinational-decode, registered-output RV32I instruction decoder for the single-issue core. It sits between instruction fetch and the register file/ALU/data-memory datapath. It splits a 32-bit instruction into register selects, a sign-extended immediate and datapath control. All outputs are registered with one-cycle latency.

---
 rtl/rv_decode_pkg.sv | 33 +++
 rtl/rv_decode_imm_gen.sv | 31 +++
 rtl/rv_decode.sv | 99 +++++++++
 tb/tb_rv_decode.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/rv_decode_pkg.sv
// Shared opcodes, ALU operation codes and the decoded-control record for rv_decode.
package rv_decode_pkg;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [5:0] ALU_ADD    = 6'b000000;
    localparam logic [5:0] ALU_SUB    = 6'b001000;
    localparam logic [5:0] ALU_SRA    = 6'b001101;
    localparam logic [5:0] ALU_JUMP   = 6'b011111;
    localparam logic [5:0] ALU_BRANCH = 6'b010000;

    localparam logic [31:0] NOP = 32'h00000013;

    typedef struct packed {
        logic        wb_sel;
        logic [4:0]  read_sel1;
        logic [4:0]  read_sel2;
        logic [4:0]  write_sel;
        logic        wen;
        logic [31:0] imm32;
        logic        op_b_sel;
        logic [5:0]  alu_ctrl;
        logic        mem_wen;
    } dec_t;

endpackage

// File: rtl/rv_decode_imm_gen.sv
// RV32I immediate generator: picks the I/S/B/U/J format from the opcode and sign-extends.
module rv_decode_imm_gen
    import rv_decode_pkg::*;
(
    input  logic [31:0] instr_i,
    output logic [31:0] imm_o
);

    logic [6:0] opcode;
    assign opcode = instr_i[6:0];

    always_comb begin
        imm_o = '0;
        case (opcode)
            OPC_IMM, OPC_LOAD, OPC_JALR:
                imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
            OPC_STORE:
                imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            OPC_BRANCH:
                imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                         instr_i[11:8], 1'b0};
            OPC_LUI:
                imm_o = {instr_i[31:12], 12'b0};
            OPC_JAL:
                imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                         instr_i[30:21], 1'b0};
            default: imm_o = '0;
        endcase
    end

endmodule

// File: rtl/rv_decode.sv
// RV32I decoder: combinational field/control decode feeding a single output register stage.
module rv_decode
    import rv_decode_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] instruction,
    output logic        wb_sel,
    output logic [4:0]  read_sel1,
    output logic [4:0]  read_sel2,
    output logic [4:0]  write_sel,
    output logic        wEn,
    output logic [31:0] imm32,
    output logic        op_B_sel,
    output logic [5:0]  ALU_Control,
    output logic        mem_wEn
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7_5;
    logic [31:0] imm_w;
    dec_t        dec_d, dec_q;

    assign opcode   = instruction[6:0];
    assign funct3   = instruction[14:12];
    assign funct7_5 = instruction[30];

    rv_decode_imm_gen u_imm_gen (
        .instr_i (instruction),
        .imm_o   (imm_w)
    );

    always_comb begin
        dec_d           = '0;
        dec_d.read_sel1 = instruction[19:15];
        dec_d.read_sel2 = instruction[24:20];
        dec_d.write_sel = instruction[11:7];
        // imm_gen already yields zero for R-type and unsupported opcodes.
        dec_d.imm32     = imm_w;
        case (opcode)
            OPC_R: begin
                dec_d.wen      = 1'b1;
                dec_d.alu_ctrl = {2'b00, funct7_5, funct3};
            end
            OPC_IMM: begin
                dec_d.wen      = 1'b1;
                dec_d.op_b_sel = 1'b1;
                dec_d.alu_ctrl = (funct3 == 3'b101 && funct7_5) ? ALU_SRA : {3'b000, funct3};
            end
            OPC_LOAD: begin
                dec_d.wen      = 1'b1;
                dec_d.op_b_sel = 1'b1;
                dec_d.wb_sel   = 1'b1;
                dec_d.alu_ctrl = ALU_ADD;
            end
            OPC_STORE: begin
                dec_d.op_b_sel = 1'b1;
                dec_d.mem_wen  = 1'b1;
                dec_d.alu_ctrl = ALU_ADD;
            end
            OPC_BRANCH: begin
                dec_d.alu_ctrl = ALU_BRANCH | {3'b000, funct3};
            end
            OPC_JAL, OPC_JALR: begin
                dec_d.wen      = 1'b1;
                dec_d.op_b_sel = 1'b1;
                dec_d.alu_ctrl = ALU_JUMP;
            end
            OPC_LUI: begin
                // rs1 forced to x0 so the ALU produces x0 + imm.
                dec_d.read_sel1 = '0;
                dec_d.wen       = 1'b1;
                dec_d.op_b_sel  = 1'b1;
                dec_d.alu_ctrl  = ALU_ADD;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            dec_q <= '0;
        end else begin
            dec_q <= dec_d;
        end
    end

    assign wb_sel      = dec_q.wb_sel;
    assign read_sel1   = dec_q.read_sel1;
    assign read_sel2   = dec_q.read_sel2;
    assign write_sel   = dec_q.write_sel;
    assign wEn         = dec_q.wen;
    assign imm32       = dec_q.imm32;
    assign op_B_sel    = dec_q.op_b_sel;
    assign ALU_Control = dec_q.alu_ctrl;
    assign mem_wEn     = dec_q.mem_wen;

endmodule

// File: tb/tb_rv_decode.sv
// Scoreboard bench for rv_decode: directed instructions with hand-decoded expectations.
module tb_rv_decode;

    typedef struct packed {
        logic        wb;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        wen;
        logic [31:0] imm;
        logic        bsel;
        logic [5:0]  alu;
        logic        mwen;
    } exp_t;

    typedef struct {
        exp_t        e;
        logic [31:0] ins;
        int          idx;
    } sb_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instruction = 32'h0;
    logic        wb_sel, wEn, op_B_sel, mem_wEn;
    logic [4:0]  read_sel1, read_sel2, write_sel;
    logic [31:0] imm32;
    logic [5:0]  ALU_Control;

    int   checks = 0;
    int   errors = 0;
    int   vec_n  = 0;
    sb_t  sb[$];
    sb_t  mon_item;
    exp_t act;

    rv_decode dut (
        .clock       (clock),
        .reset       (reset),
        .instruction (instruction),
        .wb_sel      (wb_sel),
        .read_sel1   (read_sel1),
        .read_sel2   (read_sel2),
        .write_sel   (write_sel),
        .wEn         (wEn),
        .imm32       (imm32),
        .op_B_sel    (op_B_sel),
        .ALU_Control (ALU_Control),
        .mem_wEn     (mem_wEn)
    );

    always #5 clock = ~clock;

    // Driver works on the falling edge; expectation is pushed alongside the stimulus.
    task automatic issue(input logic rst, input logic [31:0] ins, input exp_t e);
        sb_t it;
        @(negedge clock);
        reset       = rst;
        instruction = ins;
        it.e   = e;
        it.ins = ins;
        it.idx = vec_n;
        vec_n++;
        sb.push_back(it);
    endtask

    // Monitor: each rising edge produces one decoded result for the oldest pending entry.
    always @(posedge clock) begin
        #1;
        if (sb.size() > 0) begin
            mon_item = sb.pop_front();
            act = '{wb: wb_sel, rs1: read_sel1, rs2: read_sel2, rd: write_sel, wen: wEn,
                    imm: imm32, bsel: op_B_sel, alu: ALU_Control, mwen: mem_wEn};
            checks++;
            if (act !== mon_item.e) begin
                errors++;
                $display("FAIL vec%0d ins=%08h got wb=%b rs1=%0d rs2=%0d rd=%0d wen=%b imm=%08h bsel=%b alu=%06b mwen=%b want wb=%b rs1=%0d rs2=%0d rd=%0d wen=%b imm=%08h bsel=%b alu=%06b mwen=%b",
                         mon_item.idx, mon_item.ins,
                         act.wb, act.rs1, act.rs2, act.rd, act.wen, act.imm, act.bsel, act.alu,
                         act.mwen,
                         mon_item.e.wb, mon_item.e.rs1, mon_item.e.rs2, mon_item.e.rd,
                         mon_item.e.wen, mon_item.e.imm, mon_item.e.bsel, mon_item.e.alu,
                         mon_item.e.mwen);
            end
        end
    end

    localparam exp_t ZERO = '0;

    initial begin
        int budget;
        // Reset held two cycles with addi on the bus.
        issue(1'b1, 32'hFFF00593, ZERO);
        issue(1'b1, 32'hFFF00593, ZERO);
        // addi a1, zero, -1
        issue(1'b0, 32'hFFF00593, '{1'b0, 5'd0, 5'd31, 5'd11, 1'b1, 32'hFFFFFFFF, 1'b1,
                                    6'b000000, 1'b0});
        // nop
        issue(1'b0, 32'h00000013, '{1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 32'h0, 1'b1, 6'b000000, 1'b0});
        // sub x3, x1, x2
        issue(1'b0, 32'h402081B3, '{1'b0, 5'd1, 5'd2, 5'd3, 1'b1, 32'h0, 1'b0, 6'b001000, 1'b0});
        // sw x5, -4(x2)
        issue(1'b0, 32'hFE512E23, '{1'b0, 5'd2, 5'd5, 5'd28, 1'b0, 32'hFFFFFFFC, 1'b1,
                                    6'b000000, 1'b1});
        // lw x6, 12(x7)
        issue(1'b0, 32'h00C3A303, '{1'b1, 5'd7, 5'd12, 5'd6, 1'b1, 32'd12, 1'b1, 6'b000000, 1'b0});
        // beq x1, x2, +8
        issue(1'b0, 32'h00208463, '{1'b0, 5'd1, 5'd2, 5'd8, 1'b0, 32'd8, 1'b0, 6'b010000, 1'b0});
        // bne x1, x2, -8
        issue(1'b0, 32'hFE209CE3, '{1'b0, 5'd1, 5'd2, 5'd25, 1'b0, 32'hFFFFFFF8, 1'b0,
                                    6'b010001, 1'b0});
        // srai x5, x6, 3
        issue(1'b0, 32'h40335293, '{1'b0, 5'd6, 5'd3, 5'd5, 1'b1, 32'h00000403, 1'b1,
                                    6'b001101, 1'b0});
        // srli x5, x6, 3
        issue(1'b0, 32'h00335293, '{1'b0, 5'd6, 5'd3, 5'd5, 1'b1, 32'd3, 1'b1, 6'b000101, 1'b0});
        // slt x4, x5, x6
        issue(1'b0, 32'h0062A233, '{1'b0, 5'd5, 5'd6, 5'd4, 1'b1, 32'h0, 1'b0, 6'b000010, 1'b0});
        // sra x4, x5, x6
        issue(1'b0, 32'h4062D233, '{1'b0, 5'd5, 5'd6, 5'd4, 1'b1, 32'h0, 1'b0, 6'b001101, 1'b0});
        // jal ra, +16
        issue(1'b0, 32'h010000EF, '{1'b0, 5'd0, 5'd16, 5'd1, 1'b1, 32'd16, 1'b1, 6'b011111, 1'b0});
        // jal x0, -4
        issue(1'b0, 32'hFFDFF06F, '{1'b0, 5'd31, 5'd29, 5'd0, 1'b1, 32'hFFFFFFFC, 1'b1,
                                    6'b011111, 1'b0});
        // jalr x0, 0(x1)
        issue(1'b0, 32'h00008067, '{1'b0, 5'd1, 5'd0, 5'd0, 1'b1, 32'h0, 1'b1, 6'b011111, 1'b0});
        // lui x5, 0x12345: rs1 forced to 0
        issue(1'b0, 32'h123452B7, '{1'b0, 5'd0, 5'd3, 5'd5, 1'b1, 32'h12345000, 1'b1,
                                    6'b000000, 1'b0});
        // auipc x5, 0x12345: bubble with raw selects
        issue(1'b0, 32'h12345297, '{1'b0, 5'd8, 5'd3, 5'd5, 1'b0, 32'h0, 1'b0, 6'b000000, 1'b0});
        // ecall: bubble
        issue(1'b0, 32'h00000073, ZERO);
        // Reset mid-stream over a sub, then release straight into lw.
        issue(1'b1, 32'h402081B3, ZERO);
        issue(1'b0, 32'h00C3A303, '{1'b1, 5'd7, 5'd12, 5'd6, 1'b1, 32'd12, 1'b1, 6'b000000, 1'b0});

        budget = 10;
        while (sb.size() > 0 && budget > 0) begin
            @(posedge clock);
            budget--;
        end
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
